// File: rtl/apb_pkg.sv
// Shared APB master definitions: FSM state encoding, default bus widths and
// the strobe-width helper.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apbState_t;

    localparam int APB_ADDR_W = 16;
    localparam int APB_DATA_W = 32;

    function automatic int strbWidth(input int dataW);
        return dataW / 8;
    endfunction

endpackage

// File: rtl/apb_rr_arb2.sv
// Two-way round-robin grant: a lone request wins; on contention the client
// not served last wins. The pointer only moves on the update strobe.
module apb_rr_arb2 (
    input  logic       iPCLK,
    input  logic       iPRESET,
    input  logic [1:0] iReq,
    input  logic       iUpdate,
    input  logic       iServed,
    output logic [1:0] oGrant
);

    logic lastServed;

    // Reset value 1 makes client 0 the favoured one after reset
    always_ff @(posedge iPCLK or posedge iPRESET) begin
        if (iPRESET)      lastServed <= 1'b1;
        else if (iUpdate) lastServed <= iServed;
    end

    always_comb begin
        oGrant = iReq;
        if (&iReq) oGrant = lastServed ? 2'b01 : 2'b10;
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Two-client APB master with round-robin arbitration and IDLE/SETUP/ACCESS
// sequencing. Define APB_TIMEOUT_EN to bound the ACCESS phase to TIMEOUT cycles.
module apb_master_arbiter
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 255
) (
    input  logic                iPCLK,
    input  logic                iPRESET,
    input  logic                iREQ0,
    input  logic                iREQ1,
    input  logic                iWRITE0,
    input  logic                iWRITE1,
    input  logic [ADDR_W-1:0]   iADDR0,
    input  logic [ADDR_W-1:0]   iADDR1,
    input  logic [DATA_W-1:0]   iWDATA0,
    input  logic [DATA_W-1:0]   iWDATA1,
    input  logic [DATA_W/8-1:0] iSTRB0,
    input  logic [DATA_W/8-1:0] iSTRB1,
    output logic                oDONE0,
    output logic                oDONE1,
    output logic [DATA_W-1:0]   oRDATA,
    output logic                oERR,
    output logic                oBUSY,
    output logic                oPSEL,
    output logic                oPENABLE,
    output logic                oPWRITE,
    output logic [ADDR_W-1:0]   oPADDR,
    output logic [DATA_W-1:0]   oPWDATA,
    output logic [DATA_W/8-1:0] oPSTRB,
    input  logic [DATA_W-1:0]   iPRDATA,
    input  logic                iPREADY,
    input  logic                iPSLVERR
);

    localparam int STRB_W = strbWidth(DATA_W);

    apbState_t   state, nextState;
    logic [1:0]  grant;
    logic        owner;
    logic        start, complete, timedOut;
    logic        selWrite;

    apb_rr_arb2 uArb (
        .iPCLK   (iPCLK),
        .iPRESET (iPRESET),
        .iReq    ({iREQ1, iREQ0}),
        .iUpdate (complete),
        .iServed (owner),
        .oGrant  (grant)
    );

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] toCnt;

    always_ff @(posedge iPCLK or posedge iPRESET) begin
        if (iPRESET)               toCnt <= '0;
        else if (state == SETUP)   toCnt <= '0;
        else if (state == ACCESS)  toCnt <= toCnt + 1'b1;
    end
`endif

    always_ff @(posedge iPCLK or posedge iPRESET) begin
        if (iPRESET) state <= IDLE;
        else         state <= nextState;
    end

    // No grant while a done pulse is out, so the finishing client can drop its request
    always_comb begin
        nextState = state;
        start     = 1'b0;
        complete  = 1'b0;
        timedOut  = 1'b0;
        case (state)
            IDLE: begin
                if ((iREQ0 || iREQ1) && !(oDONE0 || oDONE1)) begin
                    start     = 1'b1;
                    nextState = SETUP;
                end
            end
            SETUP: nextState = ACCESS;
            ACCESS: begin
                if (iPREADY) begin
                    complete  = 1'b1;
                    nextState = IDLE;
                end
`ifdef APB_TIMEOUT_EN
                else if (toCnt == CNT_W'(TIMEOUT - 1)) begin
                    timedOut  = 1'b1;
                    complete  = 1'b1;
                    nextState = IDLE;
                end
`endif
            end
            default: nextState = IDLE;
        endcase
    end

    assign selWrite = grant[1] ? iWRITE1 : iWRITE0;
    assign oBUSY    = (state != IDLE);

    always_ff @(posedge iPCLK or posedge iPRESET) begin
        if (iPRESET) begin
            owner    <= 1'b0;
            oDONE0   <= 1'b0;
            oDONE1   <= 1'b0;
            oRDATA   <= '0;
            oERR     <= 1'b0;
            oPSEL    <= 1'b0;
            oPENABLE <= 1'b0;
            oPWRITE  <= 1'b0;
            oPADDR   <= '0;
            oPWDATA  <= '0;
            oPSTRB   <= '0;
        end else begin
            oDONE0 <= complete && !owner;
            oDONE1 <= complete && owner;
            if (start) begin
                owner   <= grant[1];
                oPSEL   <= 1'b1;
                oPWRITE <= selWrite;
                oPADDR  <= grant[1] ? iADDR1  : iADDR0;
                oPWDATA <= grant[1] ? iWDATA1 : iWDATA0;
                oPSTRB  <= selWrite ? (grant[1] ? iSTRB1 : iSTRB0) : STRB_W'(0);
            end
            if (state == SETUP) oPENABLE <= 1'b1;
            if (complete) begin
                oPSEL    <= 1'b0;
                oPENABLE <= 1'b0;
                oRDATA   <= (timedOut || oPWRITE) ? '0 : iPRDATA;
                oERR     <= timedOut || iPSLVERR;
            end
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed + randomized bench for apb_master_arbiter against a transaction-level
// model of the client/arbitration/slave behaviour.
module tb_apb_master_arbiter;

    logic        iPCLK, iPRESET;
    logic [1:0]  req, wr;
    logic [15:0] addr  [2];
    logic [31:0] wdata [2];
    logic [3:0]  strb  [2];
    logic        oDONE0, oDONE1, oERR, oBUSY, oPSEL, oPENABLE, oPWRITE;
    logic [31:0] oRDATA, oPWDATA, iPRDATA;
    logic [15:0] oPADDR;
    logic [3:0]  oPSTRB;
    logic        iPREADY, iPSLVERR;

    int checks = 0, failures = 0;
    int ls = 1;
    logic [31:0] lastRd = 0;
    int n;

    apb_master_arbiter #(.ADDR_W(16), .DATA_W(32), .TIMEOUT(8)) dut (
        .iPCLK(iPCLK), .iPRESET(iPRESET),
        .iREQ0(req[0]), .iREQ1(req[1]), .iWRITE0(wr[0]), .iWRITE1(wr[1]),
        .iADDR0(addr[0]), .iADDR1(addr[1]), .iWDATA0(wdata[0]), .iWDATA1(wdata[1]),
        .iSTRB0(strb[0]), .iSTRB1(strb[1]),
        .oDONE0(oDONE0), .oDONE1(oDONE1), .oRDATA(oRDATA), .oERR(oERR), .oBUSY(oBUSY),
        .oPSEL(oPSEL), .oPENABLE(oPENABLE), .oPWRITE(oPWRITE), .oPADDR(oPADDR),
        .oPWDATA(oPWDATA), .oPSTRB(oPSTRB),
        .iPRDATA(iPRDATA), .iPREADY(iPREADY), .iPSLVERR(iPSLVERR)
    );

    initial iPCLK = 1'b0;
    always #5 iPCLK = ~iPCLK;

    task automatic tick();
        @(posedge iPCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic allZero();
        return ~|{oDONE0, oDONE1, oRDATA, oERR, oBUSY, oPSEL, oPENABLE,
                  oPWRITE, oPADDR, oPWDATA, oPSTRB};
    endfunction

    task automatic setClient(input int c, input logic w, input logic [15:0] a,
                             input logic [31:0] d, input logic [3:0] s);
        wr[c] = w; addr[c] = a; wdata[c] = d; strb[c] = s; req[c] = 1'b1;
    endtask

    task automatic randClient(input int c);
        if (!req[c]) setClient(c, 1'($urandom), 16'($urandom), $urandom, 4'($urandom));
    endtask

    task automatic waitSetup(output int cnt);
        cnt = 0;
        do begin
            tick(); cnt++;
            if (!oPSEL) begin
                chk("idle_done", {oDONE0, oDONE1}, 0);
                chk("idle_rdata", oRDATA, lastRd);
            end
        end while (!oPSEL && cnt < 8);
        chk("setup_seen", oPSEL, 1);
    endtask

    // One full transfer: the model picks the winner from the held requests and
    // the slave inserts w wait states before responding.
    task automatic runXfer(input int w, input logic serr, input logic [31:0] rd, output int cnt);
        int pick;
        logic [15:0] eA; logic eW; logic [31:0] eD; logic [3:0] eS;
        pick = (req == 2'b11) ? 1 - ls : (req[1] ? 1 : 0);
        eA = addr[pick]; eW = wr[pick]; eD = wdata[pick]; eS = eW ? strb[pick] : 4'h0;
        waitSetup(cnt);
        if (!oPSEL) return;
        chk("setup_penable", oPENABLE, 0);
        chk("setup_busy", oBUSY, 1);
        chk("setup_paddr", oPADDR, eA);
        chk("setup_pstrb", oPSTRB, eS);
        iPREADY = 1'b0;
        for (int i = 0; i <= w; i++) begin
            tick();
            chk("acc_ctl", {oPSEL, oPENABLE, oBUSY, oDONE0, oDONE1}, 5'b11100);
            chk("acc_payload", {oPWRITE, oPADDR, oPSTRB}, {eW, eA, eS});
            chk("acc_pwdata", oPWDATA, eD);
            if (i == w) begin
                iPREADY = 1'b1; iPRDATA = rd; iPSLVERR = serr;
            end else begin
                iPRDATA = $urandom;
            end
        end
        tick();
        lastRd = eW ? 32'h0 : rd;
        chk("done0", oDONE0, pick == 0);
        chk("done1", oDONE1, pick == 1);
        chk("done_rdata", oRDATA, lastRd);
        chk("done_err", oERR, serr);
        chk("done_bus", {oPSEL, oPENABLE, oBUSY}, 0);
        ls = pick; req[pick] = 1'b0;
        iPREADY = 1'b0; iPSLVERR = 1'b0;
    endtask

    initial begin
        req = 0; wr = 0;
        for (int c = 0; c < 2; c++) begin addr[c] = 0; wdata[c] = 0; strb[c] = 0; end
        iPRDATA = 0; iPREADY = 0; iPSLVERR = 0;
        iPRESET = 1'b1;
        tick(); tick();
        chk("reset_outputs", allZero(), 1);
        iPRESET = 1'b0;
        tick();
        chk("post_reset_idle", allZero(), 1);

        // Client 0 write, zero wait states
        setClient(0, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF);
        runXfer(0, 1'b0, 32'hCAFE0000, n);
        chk("t1_grant_latency", n, 1);

        // Client 1 read with 3 wait states
        setClient(1, 1'b0, 16'h0024, 32'h55AA55AA, 4'hF);
        runXfer(3, 1'b0, 32'h12345678, n);

        // Both clients contend: grants must alternate
        setClient(0, 1'b1, 16'h0100, 32'h11111111, 4'h3);
        setClient(1, 1'b1, 16'h0200, 32'h22222222, 4'hC);
        for (int k = 0; k < 4; k++) begin
            runXfer(k % 2, 1'b0, $urandom, n);
            if (k < 2) randClient(ls);
        end

        // Slave error, then a clean transfer
        setClient(0, 1'b1, 16'h00FC, 32'h0BADF00D, 4'hF);
        runXfer(1, 1'b1, 32'h0, n);
        setClient(0, 1'b0, 16'h0030, 32'h0, 4'hF);
        runXfer(0, 1'b0, 32'hA5A5A5A5, n);

        // Reset during ACCESS aborts without a done pulse
        setClient(1, 1'b0, 16'h0040, 32'h0, 4'hF);
        waitSetup(n);
        tick();
        chk("pre_reset_access", oPENABLE, 1);
        iPRESET = 1'b1;
        #1;
        chk("async_reset_zero", allZero(), 1);
        tick();
        chk("reset_hold_zero", allZero(), 1);
        iPRESET = 1'b0;
        ls = 1; lastRd = 0;
        runXfer(0, 1'b0, 32'h76543210, n);
        chk("restart_latency", n, 1);

`ifdef APB_TIMEOUT_EN
        // Slave never ready: terminated after 8 ACCESS cycles with an error
        setClient(0, 1'b0, 16'h0050, 32'h0, 4'hF);
        waitSetup(n);
        iPREADY = 1'b0; iPRDATA = 32'hFFFFFFFF;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("to_access", {oPSEL, oPENABLE, oDONE0}, 3'b110);
        end
        tick();
        chk("to_done", {oDONE0, oDONE1}, 2'b10);
        chk("to_err", oERR, 1);
        chk("to_rdata", oRDATA, 0);
        chk("to_psel", {oPSEL, oPENABLE}, 0);
        req[0] = 1'b0; ls = 0; lastRd = 0;
`else
        // Without the timeout a long wait still completes normally
        setClient(0, 1'b0, 16'h0050, 32'h0, 4'hF);
        runXfer(12, 1'b0, 32'h0F0F0F0F, n);
`endif

        // Randomized traffic
        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(1, 0) == 1) randClient(0);
            if ($urandom_range(1, 0) == 1) randClient(1);
            if (req == 2'b00) randClient(k % 2);
            runXfer(int'($urandom_range(3, 0)), 1'($urandom), $urandom, n);
        end
        if (req != 2'b00) runXfer(0, 1'b0, $urandom, n);
        if (req != 2'b00) runXfer(0, 1'b0, $urandom, n);
        tick();
        chk("final_idle", {oDONE0, oDONE1, oBUSY}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/apb_master_arbiter.md
Name: apb_master_arbiter

Overview:
- Two-requester APB master: accepts simple request/done transactions from two internal clients, arbitrates round-robin, and sequences the shared APB bus through IDLE/SETUP/ACCESS.
- Drives the same PSEL/PENABLE/PWRITE/PSTRB/PADDR/PWDATA bus that the team's APB monitor and slaves observe.
- Returns read data and slave error to the granted client with a one-cycle done pulse.

Parameters:
- ADDR_W, 16, APB address width.
- DATA_W, 32, APB data width; PSTRB width = DATA_W/8.
- TIMEOUT, 255, ACCESS-phase cycle limit (used only with APB_TIMEOUT_EN).

Ports:
- iPCLK  in  1  bus clock; all logic on rising edge.
- iPRESET  in  1  asynchronous, active-high reset.
- iREQ0 / iREQ1  in  1  client request; held high with payload stable until matching oDONE.
- iWRITE0 / iWRITE1  in  1  1=write, 0=read.
- iADDR0 / iADDR1  in  ADDR_W  transfer address.
- iWDATA0 / iWDATA1  in  DATA_W  write data.
- iSTRB0 / iSTRB1  in  DATA_W/8  write byte strobes.
- oDONE0 / oDONE1  out  1  one-cycle completion pulse.
- oRDATA  out  DATA_W  read data; valid in the oDONEx cycle.
- oERR  out  1  completion error; valid in the oDONEx cycle.
- oBUSY  out  1  high in SETUP and ACCESS.
- oPSEL, oPENABLE, oPWRITE  out  1  APB control.
- oPADDR  out  ADDR_W; oPWDATA  out  DATA_W; oPSTRB  out  DATA_W/8  APB payload.
- iPRDATA  in  DATA_W; iPREADY  in  1; iPSLVERR  in  1  APB response.

Behaviour:
- Reset (async, iPRESET=1): all outputs 0, FSM=IDLE, round-robin pointer favours client 0. Reset mid-transfer aborts it and emits no oDONE.
- IDLE: if any iREQx is high, latch the winner's payload into the oP* registers, set oPSEL=1, oPENABLE=0, and go to SETUP next cycle. No request: stay in IDLE with oPSEL=0.
- Arbitration: single request wins. If both are high, the client not served last wins; the pointer updates only on completion.
- SETUP (exactly one cycle): go to ACCESS and set oPENABLE=1. oPADDR, oPWRITE, oPWDATA and oPSTRB are held stable from SETUP through the end of ACCESS.
- ACCESS: hold while iPREADY=0. On iPREADY=1:
  - register iPRDATA into oRDATA (0 on writes) and iPSLVERR into oERR;
  - pulse oDONE of the granted client next cycle;
  - drop oPSEL and oPENABLE;
  - return to IDLE.
- Minimum transfer: SETUP + 1 ACCESS cycle, then done. At least one IDLE cycle between transfers, so a client can drop iREQ after oDONE without being re-granted.
- Reads drive oPSTRB=0 (APB4 rule). oPWDATA is don't-care on reads and is driven with the latched value.
- iREQ withdrawn mid-transfer: ignored; the transfer completes and done still pulses.
- oDONE0 and oDONE1 are never high together. oRDATA and oERR hold their value until the next completion.

Optional Feature:
- Macro APB_TIMEOUT_EN.
- Defined: an ACCESS-cycle counter is cleared on entering ACCESS. If it reaches TIMEOUT with iPREADY still 0:
  - terminate the transfer: drop oPSEL and oPENABLE, return to IDLE;
  - pulse oDONEx with oERR=1 and oRDATA=0.
- Not defined: no counter; ACCESS waits indefinitely for iPREADY.

Decomposition:
- Shared package apb_pkg: FSM state encoding (IDLE, SETUP, ACCESS), default ADDR_W/DATA_W constants, strobe-width function.
- Sub-module apb_rr_arb2: 2-way round-robin grant logic with a last-served pointer and an update strobe.

Test Plan:
- Client 0 write, addr 0x0010, data 0xDEADBEEF, strb 0xF, iPREADY tied 1 -> SETUP then ACCESS; oDONE0 pulses 2 cycles after the grant cycle; monitor shows the write; oERR=0.
- Client 1 read, addr 0x0024, slave waits 3 cycles then returns 0x12345678 -> 3 ACCESS wait cycles; oRDATA=0x12345678 with oDONE1; oPSTRB=0 throughout.
- Both clients request continuously -> grants alternate 0,1,0,1 over 4 transfers; no back-to-back grant to one client.
- Slave returns iPSLVERR=1 on a write to 0x00FC -> oERR=1 with oDONE0; next transfer proceeds normally.
- iPRESET asserted during ACCESS -> all outputs 0 immediately, no oDONE; after release a pending request restarts from SETUP.
- APB_TIMEOUT_EN with TIMEOUT=8 and iPREADY stuck at 0 -> after 8 ACCESS cycles, oDONEx with oERR=1 and oRDATA=0; oPSEL drops.
